// File: rtl/sp_ram_bist.sv
// Self-test initiator for one single-port RAM: writes a seeded ramp,
// reads it back through a read_lat-deep compare pipe and reports the result.
`timescale 1ns/1ps
module sp_ram_bist #(
    parameter int data_width = 12,
    parameter int addr_width = 6,
    parameter int read_lat   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [data_width-1:0] seed,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_wdata,
    input  logic [data_width-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width:0]   err_count,
    output logic [addr_width-1:0] fail_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [addr_width-1:0] r_addr;
    logic                  r_we;
    logic [data_width-1:0] r_wdata;
    logic [data_width-1:0] r_seed;
    logic [addr_width:0]   r_err;
    logic [addr_width-1:0] r_fail;
    logic                  r_pass;
    logic [2:0]            r_drain;

    logic [read_lat-1:0]   r_pv;
    logic [addr_width-1:0] r_pa [read_lat];
    logic [data_width-1:0] r_pe [read_lat];

    logic                  w_last;
    logic                  w_mis;
    logic                  w_drain_end;
    logic [addr_width:0]   w_err_nxt;

    function automatic logic [data_width-1:0] f_exp(
        input logic [addr_width-1:0] a,
        input logic [data_width-1:0] s
    );
        return data_width'(a) + s;
    endfunction

    assign w_last      = &r_addr;
    assign w_mis       = r_pv[read_lat-1] && (ram_rdata != r_pe[read_lat-1]);
    assign w_drain_end = (r_drain == 3'(read_lat - 1));
    assign w_err_nxt   = r_err + (addr_width+1)'(w_mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_seed  <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_drain <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WRITE;
                        r_addr  <= '0;
                        r_we    <= 1'b1;
                        r_wdata <= f_exp('0, seed);
                        r_seed  <= seed;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state <= S_READ;
                        r_addr  <= '0;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_wdata <= f_exp(r_addr + 1'b1, r_seed);
                    end
                end
                S_READ: begin
                    r_addr <= r_addr + 1'b1;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end
                end
                S_DRAIN: begin
                    // the final compare lands on this edge, so use w_err_nxt
                    if (w_drain_end) begin
                        r_state <= S_DONE;
                        r_pass  <= (w_err_nxt == '0);
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_mis) begin
                r_err <= w_err_nxt;
                if (r_err == '0) begin
                    r_fail <= r_pa[read_lat-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < read_lat; i++) begin
                r_pa[i] <= '0;
                r_pe[i] <= '0;
            end
        end else begin
            r_pv[0] <= (r_state == S_READ);
            r_pa[0] <= r_addr;
            r_pe[0] <= f_exp(r_addr, r_seed);
            for (int i = 1; i < read_lat; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_addr = r_fail;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Directed bench for sp_ram_bist: behavioural RAMs with fault modes,
// one instance at read_lat=1 and one at read_lat=3.
`timescale 1ns/1ps
module tb_sp_ram_bist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic [11:0] seed = '0;
    logic [11:0] seed3 = 12'h5A5;

    logic        we1, busy1, done1, pass1;
    logic [5:0]  addr1, fail1;
    logic [11:0] wdata1, rdata1;
    logic [6:0]  err1;

    logic        we3, busy3, done3, pass3;
    logic [5:0]  addr3, fail3;
    logic [11:0] wdata3, rdata3;
    logic [6:0]  err3;

    int checks = 0;
    int errors = 0;

    int          mode = 0;
    int          dcyc, dcyc2, d3, n_wr, bad_wr, gap;
    logic [11:0] w0, w1;
    logic        busy0, pass0;

    always #5 clk = ~clk;

    sp_ram_bist #(.data_width(12), .addr_width(6), .read_lat(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1),
        .ram_rdata(rdata1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_addr(fail1)
    );

    sp_ram_bist #(.data_width(12), .addr_width(6), .read_lat(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed3),
        .ram_we(we3), .ram_addr(addr3), .ram_wdata(wdata3),
        .ram_rdata(rdata3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_addr(fail3)
    );

    // read_lat=1 RAM with selectable faults
    logic [11:0] mem1 [64];
    logic [11:0] rd1;
    logic [5:0]  rda1;
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= wdata1;
        rd1  <= mem1[addr1];
        rda1 <= addr1;
    end
    assign rdata1 = (mode == 2) ? 12'h000 :
                    ((mode == 1) && (rda1 == 6'd5)) ? (rd1 ^ 12'h001) : rd1;

    // read_lat=3 RAM
    logic [11:0] mem3 [64];
    logic [11:0] p3a, p3b, p3c;
    always @(posedge clk) begin
        if (we3) mem3[addr3] <= wdata3;
        p3a <= mem3[addr3];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rdata3 = p3c;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [11:0] sd, input bit hold, input bit pulse);
        logic [11:0] e;
        dcyc = -1; dcyc2 = -1; n_wr = 0; bad_wr = 0; gap = 0;
        w0 = 12'hBAD; w1 = 12'hBAD;
        repeat (2) @(negedge clk);
        start = 1'b1;
        seed  = sd;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (!hold) start = pulse && (k == 49);
            if (k == 0) begin
                busy0 = busy1;
                pass0 = pass1;
            end
            if (we1) begin
                n_wr++;
                e = 12'(addr1) + sd;
                if (wdata1 !== e) bad_wr++;
                if (addr1 == 6'd0) w0 = wdata1;
                if (addr1 == 6'd1) w1 = wdata1;
            end
            if (hold && dcyc > 0 && !busy1) gap++;
            if (done1) begin
                if (dcyc < 0) begin
                    dcyc = k + 1;
                    if (!hold) break;
                end else begin
                    dcyc2 = k + 1;
                    start = 1'b0;
                    break;
                end
            end
        end
    endtask

    initial begin
        #12;
        chk("rst_we",    we1,    0);
        chk("rst_addr",  addr1,  0);
        chk("rst_wdata", wdata1, 0);
        chk("rst_busy",  busy1,  0);
        chk("rst_done",  done1,  0);
        chk("rst_pass",  pass1,  0);
        chk("rst_err",   err1,   0);
        chk("rst_fail",  fail1,  0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        run(12'h000, 0, 0);
        chk("r1_busy0", busy0,  1);
        chk("r1_done",  dcyc,   130);
        chk("r1_pass",  pass1,  1);
        chk("r1_err",   err1,   0);
        chk("r1_fail",  fail1,  0);
        chk("r1_nwr",   n_wr,   64);
        chk("r1_badwr", bad_wr, 0);
        chk("r1_w0",    w0,     12'h000);
        chk("r1_w1",    w1,     12'h001);
        @(posedge clk);
        #1;
        chk("r1_done_pulse", done1, 0);
        chk("r1_idle",       busy1, 0);
        chk("r1_pass_held",  pass1, 1);

        mode = 1;
        run(12'h000, 0, 0);
        chk("flip_pass0", pass0, 0);
        chk("flip_done",  dcyc,  130);
        chk("flip_pass",  pass1, 0);
        chk("flip_err",   err1,  1);
        chk("flip_fail",  fail1, 5);

        mode = 2;
        run(12'h000, 0, 0);
        chk("stuck_pass", pass1, 0);
        chk("stuck_err",  err1,  63);
        chk("stuck_fail", fail1, 1);

        mode = 0;
        run(12'hFFF, 0, 1);
        chk("sfff_done",  dcyc,   130);
        chk("sfff_w0",    w0,     12'hFFF);
        chk("sfff_w1",    w1,     12'h000);
        chk("sfff_badwr", bad_wr, 0);
        chk("sfff_pass",  pass1,  1);
        chk("sfff_err",   err1,   0);

        repeat (2) @(negedge clk);
        start = 1'b1;
        seed  = 12'h0AA;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (we1 && addr1 == 6'd20) break;
            @(posedge clk);
            #1;
        end
        chk("mid_at20", {we1, addr1}, {1'b1, 6'd20});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_we",   we1,   0);
        chk("mid_busy", busy1, 0);
        chk("mid_addr", addr1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(12'h123, 0, 0);
        chk("rerun_done", dcyc,  130);
        chk("rerun_pass", pass1, 1);
        chk("rerun_err",  err1,  0);

        run(12'h040, 1, 0);
        chk("hold_done1", dcyc,  130);
        chk("hold_gap",   gap,   1);
        chk("hold_done2", dcyc2, 261);
        chk("hold_pass",  pass1, 1);

        repeat (2) @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        d3 = -1;
        for (int k = 0; k < 400; k++) begin
            if (done3) begin
                d3 = k + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("lat3_done", d3,    132);
        chk("lat3_pass", pass3, 1);
        chk("lat3_err",  err3,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_bist.md
# sp_ram_bist

Built-in self-test controller that acts as the initiator for one `sp_ram` instance. It takes the RAM port that a testbench would otherwise drive, fills every address with a seeded pattern, reads every address back, and compares each read against the expected value. Results go out as a pass flag, an error count and the first failing address. It sits between system control logic and a single-port RAM, and is instantiated once per RAM under test.

## Interface
- `data_width`, 12, RAM word width
- `addr_width`, 6, RAM address width; depth N = 2**addr_width
- `read_lat`, 1, cycles from `ram_addr` presented to `ram_rdata` valid; legal values 1..4
- `clk`  input  1  single clock, all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  begin a test run; sampled only in IDLE
- `seed`  input  data_width  pattern offset; captured on the cycle `start` is accepted
- `ram_we`  output  1  to RAM `we`
- `ram_addr`  output  addr_width  to RAM `addr`
- `ram_wdata`  output  data_width  to RAM `data_in`
- `ram_rdata`  input  data_width  from RAM `data_out`
- `busy`  output  1  high from the cycle after `start` is accepted until DONE is left
- `done`  output  1  one-cycle pulse at the end of a run
- `pass`  output  1  1 when the last run had zero mismatches; held until the next accepted `start`
- `err_count`  output  addr_width+1  mismatches in the current or last run
- `fail_addr`  output  addr_width  address of the first mismatch; 0 if none

## Operation
- Pattern rule: expected(a) = (zero-extend(a) + seed_q) mod 2**data_width.
  - If addr_width > data_width, a is truncated to data_width bits.
- States and transitions:
  - IDLE: `start`=1 moves to WRITE. On acceptance, clear `err_count`, `fail_addr` and `pass`, and capture `seed_q`.
  - WRITE: `ram_we`=1, `ram_wdata`=expected(`ram_addr`). `ram_addr` counts 0..N-1, one per cycle. After address N-1, go to READ with `ram_addr`=0.
  - READ: `ram_we`=0, `ram_addr` counts 0..N-1. Each issued address and its expected value enter a `read_lat`-deep delay pipe with a valid bit. After address N-1, go to DRAIN.
  - DRAIN: stay `read_lat` cycles while the pipe empties, then go to DONE.
  - DONE: `done`=1 and `pass`=(`err_count`==0) for one cycle, then go to IDLE.
- Compare: when the pipe output is valid and `ram_rdata` != expected, increment `err_count`.
  - If that mismatch is the first of the run, load `fail_addr` with the pipe address.
  - `err_count` never overflows, because at most N mismatches fit in addr_width+1 bits.
- `start` is ignored outside IDLE. Holding `start` high gives back-to-back runs with exactly one IDLE cycle between them.
- Outside WRITE: `ram_we`=0 and `ram_wdata`=0.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_addr`=0
  - delay pipe valid bits=0
- Cycle 0 is the rising edge that samples `start`=1 in IDLE.
  - Cycles 1..N: WRITE.
  - Cycles N+1..2N: READ.
  - Cycles 2N+1..2N+read_lat: DRAIN.
  - Cycle 2N+read_lat+1: DONE.
- For N=64 and read_lat=1, `done` is high during cycle 130 after the accepting edge.
- `ram_rdata` is sampled exactly `read_lat` edges after its address is driven. The last compare happens in the final DRAIN cycle.
- `err_count` and `fail_addr` are final when `done` is high.
- Reset mid-run: `ram_we` falls immediately and no further RAM writes occur. A new `start` after reset release runs a complete test.
- `pass` is 0 during a run. It updates only in DONE.

## Test plan
- Real `sp_ram`, init_value 0, seed=0, N=64, read_lat=1:
  - Required response: WRITE cycle k drives addr=k, wdata=k.
  - `done` pulses at cycle 130, with `pass`=1, `err_count`=0, `fail_addr`=0.
- RAM model that flips bit 0 on a read of address 5:
  - Required response: `pass`=0, `err_count`=1, `fail_addr`=5.
- RAM model whose `ram_rdata` is stuck at 0, seed=0:
  - Required response: `err_count`=63 and `fail_addr`=1, because address 0 matches.
- seed=0xFFF:
  - Required response: the write at addr 0 is 0xFFF and the write at addr 1 is 0x000 (wraps).
  - Readback then passes.
- Assert `rst_n`=0 during WRITE at addr 20:
  - Required response: `ram_we`=0 and `busy`=0 in the same cycle.
  - A restart then completes with `pass`=1.
- `start` held high:
  - Required response: a second run begins exactly one cycle after `done`.
  - `start` pulses during `busy` have no effect.
  - With read_lat=3, `done` moves to cycle 132.
